// File: rtl/rst_seq_ctrl.sv
// Reset sequencer and run control: synchronises board reset, releases NUM_CH
// downstream resets in a staggered order, then counts run cycles until halt or timeout.
module rst_seq_ctrl #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned STAGGER        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 20,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic              halt_req,
  output logic [NUM_CH-1:0] ch_rst_o,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              running,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned RelMax = (NUM_CH - 1) * STAGGER;
  localparam int unsigned RelW   = (RelMax > 0) ? $clog2(RelMax + 1) : 1;

  localparam logic [HoldW-1:0] HoldLast    = HoldW'(HOLD_CYCLES - 1);
  localparam logic [RelW-1:0]  RelLast     = RelW'(RelMax);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TimeoutEn   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    StAssert,
    StHold,
    StRelease,
    StRun,
    StStop
  } state_e;

  state_e             state_q;
  logic               sync1_q, rst_sync;
  logic [HoldW-1:0]   hold_cnt_q;
  logic [RelW-1:0]    rel_cnt_q;
  logic [NUM_CH-1:0]  rel_mask;
  logic [CNT_W-1:0]   cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      sync1_q  <= 1'b1;
      rst_sync <= sync1_q;
    end
  end

  // Channels whose release offset has been reached by the current release count.
  always_comb begin
    rel_mask = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rel_mask[i] = (RelW'(i * STAGGER) <= rel_cnt_q);
    end
  end

  assign cnt_inc = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StAssert;
      hold_cnt_q <= '0;
      rel_cnt_q  <= '0;
      ch_rst_o   <= '1;
      cycle_cnt  <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else if (sw_rst_req && (state_q != StAssert)) begin
      // Software re-reset outranks halt and timeout on the same edge.
      state_q    <= StHold;
      hold_cnt_q <= '0;
      ch_rst_o   <= '1;
      cycle_cnt  <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (rst_sync) begin
            state_q    <= StHold;
            hold_cnt_q <= '0;
          end
        end
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            state_q   <= StRelease;
            rel_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        StRelease: begin
          ch_rst_o <= ~rel_mask;
          if (rel_cnt_q == RelLast) begin
            state_q   <= StRun;
            running   <= 1'b1;
            cycle_cnt <= '0;
          end else begin
            rel_cnt_q <= rel_cnt_q + 1'b1;
          end
        end
        StRun: begin
          cycle_cnt <= cnt_inc;
          if (halt_req) begin
            state_q  <= StStop;
            running  <= 1'b0;
            done     <= 1'b1;
            ch_rst_o <= '1;
          end else if (TimeoutEn && (cycle_cnt == TimeoutLast)) begin
            state_q  <= StStop;
            running  <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
            ch_rst_o <= '1;
          end
        end
        StStop: begin
          ch_rst_o <= '1;
        end
        default: state_q <= StAssert;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: default config plus a 2-channel, zero-stagger,
// no-timeout, 4-bit-counter config.
module tb_rst_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0, sw_a = 1'b0, halt_a = 1'b0;
  logic        rst_b = 1'b0;
  logic [3:0]  ch_a;
  logic [15:0] cnt_a;
  logic        run_a, done_a, to_a;
  logic [1:0]  ch_b;
  logic [3:0]  cnt_b;
  logic        run_b, done_b, to_b;

  rst_seq_ctrl u_dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .sw_rst_req(sw_a),
    .halt_req  (halt_a),
    .ch_rst_o  (ch_a),
    .cycle_cnt (cnt_a),
    .running   (run_a),
    .done      (done_a),
    .timeout   (to_a)
  );

  rst_seq_ctrl #(
    .NUM_CH        (2),
    .HOLD_CYCLES   (2),
    .STAGGER       (0),
    .TIMEOUT_CYCLES(0),
    .CNT_W         (4)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .sw_rst_req(1'b0),
    .halt_req  (1'b0),
    .ch_rst_o  (ch_b),
    .cycle_cnt (cnt_b),
    .running   (run_b),
    .done      (done_b),
    .timeout   (to_b)
  );

  always #5 clk = ~clk;

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  typedef struct {
    int          when;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  localparam int ACh = 0, ACnt = 1, ARun = 2, ADone = 3, ATo = 4;
  localparam int BCh = 5, BCnt = 6, BRun = 7, BDone = 8, BTo = 9;

  function automatic string sel_name(input int sel);
    case (sel)
      ACh:     return "a.ch_rst_o";
      ACnt:    return "a.cycle_cnt";
      ARun:    return "a.running";
      ADone:   return "a.done";
      ATo:     return "a.timeout";
      BCh:     return "b.ch_rst_o";
      BCnt:    return "b.cycle_cnt";
      BRun:    return "b.running";
      BDone:   return "b.done";
      default: return "b.timeout";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      ACh:     return 32'(ch_a);
      ACnt:    return 32'(cnt_a);
      ARun:    return 32'(run_a);
      ADone:   return 32'(done_a);
      ATo:     return 32'(to_a);
      BCh:     return 32'(ch_b);
      BCnt:    return 32'(cnt_b);
      BRun:    return 32'(run_b);
      BDone:   return 32'(done_b);
      default: return 32'(to_b);
    endcase
  endfunction

  // Expectations are kept sorted by the tick at which they fall due.
  task automatic push(input int when, input int sel, input logic [31:0] val);
    exp_t e;
    int   idx;
    e.when = when;
    e.sel  = sel;
    e.val  = val;
    idx = q.size();
    while (idx > 0 && q[idx-1].when > when) idx--;
    q.insert(idx, e);
  endtask

  task automatic goto(input int t);
    while (tick < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: the settled state after edge N is compared on the following falling edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].when <= tick) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      n_cmp++;
      act = actual(e.sel);
      if (e.when < tick) begin
        n_fail++;
        $display("FAIL %s missed tick %0d (now %0d): want %0h", sel_name(e.sel), e.when, tick,
                 e.val);
      end else if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s @tick %0d: got %0h want %0h", sel_name(e.sel), e.when, act, e.val);
      end
    end
  end

  initial begin
    #40000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, s, s2, s3, rb, bb;

    // Power-up sequence and timeout stop (edge n of the sequence is tick b+n).
    goto(3);
    b = tick;
    push(b, ACh, 'hF); push(b, ACnt, 0); push(b, ARun, 0); push(b, ADone, 0); push(b, ATo, 0);
    push(b + 5, ACh, 'hF);
    push(b + 6, ACh, 'hE);
    push(b + 7, ACh, 'hC);
    push(b + 8, ACh, 'h8); push(b + 8, ARun, 0);
    push(b + 9, ACh, 'h0); push(b + 9, ARun, 1); push(b + 9, ACnt, 0);
    push(b + 19, ACnt, 10);
    push(b + 28, ACnt, 19); push(b + 28, ADone, 0); push(b + 28, ARun, 1);
    push(b + 29, ACnt, 20); push(b + 29, ATo, 1); push(b + 29, ADone, 1);
    push(b + 29, ACh, 'hF); push(b + 29, ARun, 0);
    push(b + 39, ACnt, 20); push(b + 39, ATo, 1); push(b + 39, ADone, 1);
    push(b + 39, ACh, 'hF); push(b + 39, ARun, 0);
    rst_a = 1'b1;

    // Software re-reset from STOP, then halt at cycle_cnt 7.
    goto(b + 39);
    s = b + 40;
    push(s, ACnt, 0); push(s, ADone, 0); push(s, ATo, 0); push(s, ACh, 'hF); push(s, ARun, 0);
    push(s + 2, ACh, 'hF);
    push(s + 3, ACh, 'hE);
    push(s + 6, ACh, 'h0); push(s + 6, ARun, 1); push(s + 6, ACnt, 0);
    push(s + 13, ACnt, 7);
    push(s + 14, ACnt, 8); push(s + 14, ATo, 0); push(s + 14, ADone, 1);
    push(s + 14, ACh, 'hF); push(s + 14, ARun, 0);
    sw_a = 1'b1;
    goto(s);
    sw_a = 1'b0;
    goto(s + 13);
    halt_a = 1'b1;
    goto(s + 14);
    halt_a = 1'b0;

    // Halt coinciding with the last budget cycle: halt wins.
    goto(s + 15);
    s2 = s + 16;
    push(s2, ADone, 0); push(s2, ACnt, 0);
    push(s2 + 6, ARun, 1); push(s2 + 6, ACnt, 0);
    push(s2 + 25, ACnt, 19);
    push(s2 + 26, ACnt, 20); push(s2 + 26, ATo, 0); push(s2 + 26, ADone, 1);
    sw_a = 1'b1;
    goto(s2);
    sw_a = 1'b0;
    goto(s2 + 25);
    halt_a = 1'b1;
    goto(s2 + 26);
    halt_a = 1'b0;

    // Re-reset, then async board reset mid-RELEASE; sw_rst_req held through ASSERT.
    s3 = s2 + 27;
    push(s3, ACh, 'hF); push(s3, ADone, 0);
    push(s3 + 3, ACh, 'hE);
    push(s3 + 4, ACh, 'hF); push(s3 + 4, ARun, 0); push(s3 + 4, ADone, 0);
    push(s3 + 4, ACnt, 0);
    sw_a = 1'b1;
    goto(s3);
    sw_a = 1'b0;
    goto(s3 + 4);
    #1;
    rst_a = 1'b0;
    sw_a  = 1'b1;
    goto(s3 + 6);
    rb = tick;
    push(rb + 5, ACh, 'hF);
    push(rb + 6, ACh, 'hE);
    push(rb + 8, ACh, 'h8);
    push(rb + 9, ACh, 'h0); push(rb + 9, ARun, 1); push(rb + 9, ACnt, 0);
    rst_a = 1'b1;
    goto(rb + 3);
    sw_a = 1'b0;
    goto(rb + 10);

    // Second configuration: simultaneous release, no timeout, saturating counter.
    bb = tick;
    push(bb, BCh, 'h3); push(bb, BCnt, 0); push(bb, BRun, 0); push(bb, BDone, 0);
    push(bb, BTo, 0);
    push(bb + 5, BCh, 'h3);
    push(bb + 6, BCh, 'h0); push(bb + 6, BRun, 1); push(bb + 6, BCnt, 0);
    push(bb + 20, BCnt, 14);
    push(bb + 21, BCnt, 15);
    push(bb + 22, BCnt, 15);
    push(bb + 31, BCnt, 15); push(bb + 31, BRun, 1); push(bb + 31, BDone, 0);
    push(bb + 31, BTo, 0);
    rst_b = 1'b1;
    goto(bb + 33);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s never checked at tick %0d: want %0h", sel_name(e.sel), e.when, e.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
